ife_dispatch_scheduler: RTL and testbench

IFE_DISPATCH_SCHEDULER -- requirements
Module: ife_dispatch_scheduler

---
 rtl/ife_dispatch_scheduler.sv | 136 +++++++++++++
 tb/tb_ife_dispatch_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ife_dispatch_scheduler.sv
// Instruction-fetch block dispatcher. Fetched blocks are queued in a FIFO and
// handed out one per cycle, round-robin, to dispatch slots of idle cores.
module ife_dispatch_scheduler #(
  parameter int BLOCK_SIZE = 4,
  parameter int NUM_CORES  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [BLOCK_SIZE*32-1:0]           in_data,
  input  logic [7:0]                         in_block_id,
  input  logic [NUM_CORES-1:0]               core_busy,
  output logic [NUM_CORES-1:0]               disp_valid,
  input  logic [NUM_CORES-1:0]               disp_ready,
  output logic [NUM_CORES*BLOCK_SIZE*32-1:0] disp_data,
  output logic [NUM_CORES*8-1:0]             disp_block_id,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic [15:0]                        dispatch_total
);

  // Handshakes: a transfer completes on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payload holds until the transfer.

  localparam int DW = BLOCK_SIZE * 32;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [DW-1:0]           mem_data_q [FIFO_DEPTH];
  logic [DW-1:0]           mem_data_d [FIFO_DEPTH];
  logic [7:0]              mem_id_q   [FIFO_DEPTH];
  logic [7:0]              mem_id_d   [FIFO_DEPTH];
  logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]           count_q, count_d;
  logic [RW-1:0]           rr_q, rr_d;
  logic [NUM_CORES-1:0]    valid_q, valid_d;
  logic [NUM_CORES*DW-1:0] data_q, data_d;
  logic [NUM_CORES*8-1:0]  id_q, id_d;
  logic [15:0]             total_q, total_d;

  logic                    push, pop, found;
  logic [RW-1:0]           chosen;
  logic [RW:0]             sum;
  logic [NUM_CORES-1:0]    eligible, hs;

  always_comb begin
    mem_data_d = mem_data_q;
    mem_id_d   = mem_id_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    rr_d       = rr_q;
    data_d     = data_q;
    id_d       = id_q;
    found      = 1'b0;
    chosen     = '0;
    sum        = '0;
    pop        = 1'b0;

    in_ready = (count_q != CW'(FIFO_DEPTH));
    push     = in_valid && in_ready;
    eligible = ~core_busy & ~valid_q;
    hs       = valid_q & disp_ready;
    valid_d  = valid_q & ~hs;

    total_d = total_q;
    for (int c = 0; c < NUM_CORES; c++) begin
      total_d = total_d + 16'(hs[c]);
    end

    // Search starts at rr_q and wraps; first eligible core wins.
    for (int i = 0; i < NUM_CORES; i++) begin
      sum = {1'b0, rr_q} + (RW+1)'(i);
      if (sum >= (RW+1)'(NUM_CORES)) begin
        sum = sum - (RW+1)'(NUM_CORES);
      end
      if (!found && eligible[sum[RW-1:0]]) begin
        found  = 1'b1;
        chosen = sum[RW-1:0];
      end
    end

    if (count_q != '0 && found) begin
      pop                          = 1'b1;
      valid_d[chosen]              = 1'b1;
      data_d[int'(chosen)*DW +: DW] = mem_data_q[rd_q];
      id_d[int'(chosen)*8 +: 8]    = mem_id_q[rd_q];
      rd_d                         = rd_q + PW'(1);
      rr_d = (chosen == RW'(NUM_CORES - 1)) ? '0 : chosen + RW'(1);
    end

    if (push) begin
      mem_data_d[wr_q] = in_data;
      mem_id_d[wr_q]   = in_block_id;
      wr_d             = wr_q + PW'(1);
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_id_q[i]   <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      rr_q    <= '0;
      valid_q <= '0;
      data_q  <= '0;
      id_q    <= '0;
      total_q <= '0;
    end else begin
      mem_data_q <= mem_data_d;
      mem_id_q   <= mem_id_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      rr_q       <= rr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      id_q       <= id_d;
      total_q    <= total_d;
    end
  end

  assign disp_valid     = valid_q;
  assign disp_data      = data_q;
  assign disp_block_id  = id_q;
  assign fifo_count     = count_q;
  assign dispatch_total = total_q;

endmodule

// File: tb/tb_ife_dispatch_scheduler.sv
// Bench for ife_dispatch_scheduler: directed scenarios plus random traffic,
// checked by a queue-based reference model and a load-observing monitor.
module tb_ife_dispatch_scheduler;

  localparam int BS    = 4;
  localparam int NC    = 2;
  localparam int DEPTH = 4;
  localparam int DW    = BS * 32;
  localparam int IW    = 8 + DW;
  localparam int EW    = 8 + IW;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic [7:0]       in_block_id = '0;
  logic [NC-1:0]    core_busy = '0;
  logic [NC-1:0]    disp_valid;
  logic [NC-1:0]    disp_ready = '0;
  logic [NC*DW-1:0] disp_data;
  logic [NC*8-1:0]  disp_block_id;
  logic [CW-1:0]    fifo_count;
  logic [15:0]      dispatch_total;

  ife_dispatch_scheduler #(.BLOCK_SIZE(BS), .NUM_CORES(NC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_block_id(in_block_id), .core_busy(core_busy),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_data(disp_data),
    .disp_block_id(disp_block_id), .fifo_count(fifo_count),
    .dispatch_total(dispatch_total)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of blocks, per-core slot flags, round-robin index.
  logic [IW-1:0] m_fifo[$];
  logic [EW-1:0] exp_q[$];
  logic [NC-1:0] m_valid = '0;
  logic [NC-1:0] m_elig;
  logic [15:0]   m_total = '0;
  logic [IW-1:0] m_item;
  int            m_rr = 0;
  int            m_sz, m_sel, m_c;
  bit            m_found;

  task automatic model_step();
    m_sz   = m_fifo.size();
    m_elig = ~core_busy & ~m_valid;
    for (int c = 0; c < NC; c++) begin
      if (m_valid[c] && disp_ready[c]) begin
        m_valid[c] = 1'b0;
        m_total    = m_total + 16'd1;
      end
    end
    if (m_sz > 0) begin
      m_found = 0;
      m_sel   = 0;
      for (int i = 0; i < NC; i++) begin
        m_c = (m_rr + i) % NC;
        if (!m_found && m_elig[m_c]) begin
          m_found = 1;
          m_sel   = m_c;
        end
      end
      if (m_found) begin
        m_item         = m_fifo.pop_front();
        m_valid[m_sel] = 1'b1;
        m_rr           = (m_sel + 1) % NC;
        exp_q.push_back({8'(m_sel), m_item});
      end
    end
    if (in_valid && m_sz != DEPTH) m_fifo.push_back({in_block_id, in_data});
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_fifo.delete();
        exp_q.delete();
        m_valid = '0;
        m_total = '0;
        m_rr    = 0;
      end else begin
        model_step();
      end
    end
  end

  // Monitor: compares status every cycle and each newly loaded slot with exp_q.
  logic [NC-1:0] mon_prev = '0;
  logic [7:0]    held_id  [NC];
  logic [DW-1:0] held_data[NC];
  logic [EW-1:0] mon_e;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("in_ready", in_ready, (m_fifo.size() != DEPTH));
      chk("fifo_count", fifo_count, m_fifo.size());
      chk("dispatch_total", dispatch_total, m_total);
      chk("disp_valid", disp_valid, m_valid);
      if (rst) begin
        mon_prev = '0;
      end else begin
        for (int c = 0; c < NC; c++) begin
          if (disp_valid[c]) begin
            if (!mon_prev[c] || disp_ready[c]) begin
              chk("load_expected", (exp_q.size() != 0), 1);
              if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("load_core", c, mon_e[EW-1 -: 8]);
                chk("load_id", disp_block_id[c*8 +: 8], mon_e[DW+7 -: 8]);
                chk("load_data", disp_data[c*DW +: DW], mon_e[DW-1:0]);
              end
              held_id[c]   = disp_block_id[c*8 +: 8];
              held_data[c] = disp_data[c*DW +: DW];
            end else begin
              chk("hold_id", disp_block_id[c*8 +: 8], held_id[c]);
              chk("hold_data", disp_data[c*DW +: DW], held_data[c]);
            end
          end
        end
        mon_prev = disp_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < BS; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_block(input logic [7:0] id);
    int  n;
    bit  acc;
    n = 0;
    if (!(in_valid && in_block_id == id)) in_data = rand_data();
    in_valid    = 1'b1;
    in_block_id = id;
    forever begin
      #1;
      acc = in_ready;
      @(negedge clk);
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("push_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst        = 1'b1;
    in_valid   = 1'b0;
    core_busy  = '0;
    disp_ready = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  bit  took;
  int  busy_pct, ready_pct;
  logic [7:0] next_id;

  initial begin
    #1;
    chk("reset_fifo_count", fifo_count, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_disp_valid", disp_valid, 0);
    chk("reset_total", dispatch_total, 0);
    chk("reset_disp_id", disp_block_id, 0);
    idle(2);
    rst = 1'b0;

    // Single block into an empty queue, visible two edges after the push.
    push_block(8'h11);
    @(posedge clk); #1;
    chk("s1_disp_valid", disp_valid, 2'b01);
    chk("s1_id", disp_block_id[7:0], 8'h11);
    chk("s1_fifo_count", fifo_count, 0);
    @(negedge clk);
    disp_ready = 2'b11;
    idle(2);
    disp_ready = 2'b00;
    chk("s1_total", dispatch_total, 1);

    // Back-to-back pushes with both cores idle.
    reset_dut();
    for (int i = 1; i <= 4; i++) push_block(8'(i));
    @(posedge clk); #1;
    chk("s2_disp_valid", disp_valid, 2'b11);
    chk("s2_ids", disp_block_id, 16'h0201);
    chk("s2_fifo_count", fifo_count, 2);
    @(negedge clk);
    disp_ready = 2'b11;
    idle(8);

    // Full queue with all cores busy: back-pressure and no pops.
    reset_dut();
    core_busy = 2'b11;
    for (int i = 0; i < 4; i++) push_block(8'h31 + 8'(i));
    #1;
    chk("s3_in_ready_full", in_ready, 0);
    chk("s3_fifo_full", fifo_count, 4);
    in_valid    = 1'b1;
    in_block_id = 8'h35;
    in_data     = rand_data();
    idle(4);
    #1;
    chk("s3_fifo_held", fifo_count, 4);
    chk("s3_no_pop", disp_valid, 2'b00);
    @(negedge clk);
    core_busy  = 2'b00;
    disp_ready = 2'b11;
    push_block(8'h35);
    idle(10);

    // Only core1 usable: three blocks go to core1 in order.
    reset_dut();
    core_busy  = 2'b01;
    disp_ready = 2'b10;
    for (int i = 0; i < 3; i++) push_block(8'h41 + 8'(i));
    idle(12);
    chk("s4_total", dispatch_total, 3);
    chk("s4_fifo_empty", fifo_count, 0);

    // Simultaneous push and pop at occupancy 2.
    reset_dut();
    core_busy = 2'b11;
    push_block(8'h51);
    push_block(8'h52);
    core_busy = 2'b00;
    push_block(8'h53);
    #1;
    chk("s5_fifo_same", fifo_count, 2);
    @(negedge clk);
    disp_ready = 2'b11;
    idle(10);

    // Asynchronous reset with both slots full and three blocks queued.
    reset_dut();
    for (int i = 0; i < 5; i++) push_block(8'h61 + 8'(i));
    #1;
    chk("s6_pre_valid", disp_valid, 2'b11);
    chk("s6_pre_count", fifo_count, 3);
    disp_ready = 2'b11;
    #1;
    rst = 1'b1;
    #1;
    chk("s6_rst_valid", disp_valid, 0);
    chk("s6_rst_count", fifo_count, 0);
    chk("s6_rst_data", disp_data, 0);
    chk("s6_rst_id", disp_block_id, 0);
    chk("s6_rst_total", dispatch_total, 0);
    chk("s6_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst        = 1'b0;
    disp_ready = 2'b00;

    // Randomized traffic in phases of differing core pressure.
    next_id = 8'h80;
    took    = 0;
    for (int ph = 0; ph < 3; ph++) begin
      busy_pct  = (ph == 0) ? 20 : (ph == 1) ? 75 : 5;
      ready_pct = (ph == 0) ? 50 : (ph == 1) ? 30 : 80;
      for (int cyc = 0; cyc < 500; cyc++) begin
        @(negedge clk);
        if (!in_valid || took) begin
          in_valid    = ($urandom_range(0, 99) < 65);
          in_block_id = next_id;
          in_data     = rand_data();
          next_id     = next_id + 8'd1;
        end
        for (int c = 0; c < NC; c++) begin
          core_busy[c]  = ($urandom_range(0, 99) < busy_pct);
          disp_ready[c] = ($urandom_range(0, 99) < ready_pct);
        end
        #1;
        took = in_valid && in_ready;
      end
    end

    @(negedge clk);
    in_valid   = 1'b0;
    core_busy  = '0;
    disp_ready = '1;
    idle(20);
    chk("final_fifo_empty", fifo_count, 0);
    chk("final_exp_q_empty", exp_q.size(), 0);
    chk("final_disp_valid", disp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
